mesh_term_inject: RTL and testbench
===================================

// Module: mesh_term_inject
// PURPOSE
//  Terminal-side injection buffer sitting directly upstream of one mesh_gnrtr terminal port.
//  Accepts packets from a terminal source, screens the destination field, and clears the Nxtjp field.
//  Queues accepted packets and presents them to the router via pndng_i_in/data_out_i_in/popin.
//  One instance per terminal: ROWS*2+COLUMS*2 instances in the top level.
// PARAMETERS
//  ROWS        4          mesh rows; legal row coordinates 0..ROWS+1
//  COLUMS      4          mesh columns; legal column coordinates 0..COLUMS+1
//  pckg_sz     40         packet width in bits
//  fifo_depth  4          queue entries (>=2, power of 2)
//  bdcst       8'hFF      {row,colum} value meaning broadcast
//  MY_ROW      0          row coordinate of this terminal
//  MY_COLUM    1          column coordinate of this terminal
// PORTS
//  clk            in   1        single clock, all logic on posedge
//  reset          in   1        synchronous, active-high
//  push           in   1        terminal source offers data_in this cycle
//  data_in        in   pckg_sz  packet from terminal source
//  full           out  1        queue holds fifo_depth entries
//  popin          in   1        router consumes head entry this cycle
//  pndng_i_in     out  1        queue non-empty; head valid on data_out_i_in
//  data_out_i_in  out  pckg_sz  head packet (show-ahead)
//  drop           out  1        one-cycle pulse: push rejected (bad dest or overflow)
//  drop_cnt       out  16       saturating count of rejected pushes
//  count          out  $clog2(fifo_depth)+1  current occupancy
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous and active-high (reset).
//  Reset values: full=0, pndng_i_in=0, data_out_i_in=0, drop=0, drop_cnt=0, count=0; rd/wr pointers=0.
//  Packet fields: [pckg_sz-1:pckg_sz-8] Nxtjp, [pckg_sz-9:pckg_sz-12] row, [pckg_sz-13:pckg_sz-16] colum.
//  Remaining fields: [pckg_sz-17] mode, [pckg_sz-18:0] payload.
//  Destination legal iff {row,colum}==bdcst, OR exactly one of these holds:
//   - row in {0,ROWS+1} and colum in 1..COLUMS
//   - colum in {0,COLUMS+1} and row in 1..ROWS
//  Destination equal to {MY_ROW,MY_COLUM} is illegal (self-addressed).
//  Stored word = data_in with Nxtjp forced to 8'h00; all other bits unchanged.
//  Push outcome:
//   - accept when push && legal && (!full || popin)
//   - reject when push && (!legal || (full && !popin)): no write; drop=1 next cycle; drop_cnt+1, saturates at 16'hFFFF.
//  Pop: popin && pndng_i_in advances rd pointer; popin while empty is ignored (no underflow, no error).
//  Latency: push accepted at edge N -> pndng_i_in=1 and data_out_i_in valid after edge N (one cycle).
//  data_out_i_in is registered-head / show-ahead. Next entry is visible the cycle after popin.
//  Simultaneous push+popin: count unchanged. When full, push is still accepted in the same cycle.
//  When count==1, the new word appears after the pop.
//  Pointers wrap modulo fifo_depth. full = (count==fifo_depth), pndng_i_in = (count!=0).
//  Ordering: strict FIFO; no reordering, no duplication.
//  Broadcast packets are queued once; replication is the router's job.
//  Reset mid-operation flushes the queue and clears drop_cnt on the next edge.
//  A push coincident with reset is discarded.
// STRUCTURE
//  mesh_pkg: field offset localparams (NXTJP_MSB/LSB, ROW_*, COL_*, MODE_BIT) and function dest_legal().
//   - dest_legal(row,col,ROWS,COLUMS,bdcst,my_row,my_col) is shared with the monitor/checker.
//  Sub-module term_fifo_core: generic sync show-ahead FIFO (push/pop/full/empty/count), param WIDTH, DEPTH.
//  Top level holds the destination screen, Nxtjp clear, drop pulse and saturating counter.
// TESTING
//  1 Reset then push {Nxtjp=8'h5A,row=2,col=0,mode=1,payload=1} at MY=(0,1).
//    -> next cycle pndng_i_in=1, data_out_i_in has Nxtjp=0; popin -> pndng_i_in=0.
//  2 Push 5 legal packets back-to-back with popin=0, depth 4.
//    -> full=1 after 4th; 5th gives drop=1, drop_cnt=1; popin x4 returns first 4 in order.
//  3 Full queue, push and popin in the same cycle -> count stays 4.
//    Head advances; new word emerges last; drop=0.
//  4 Push dest (0,0), (5,5), (2,2) and self (0,1) -> all dropped, drop_cnt=4, pndng_i_in stays 0.
//    Push dest {row,col}=8'hFF -> accepted.
//  5 popin on empty queue -> no state change, count=0, drop=0.
//    Force 70000 rejects -> drop_cnt holds 16'hFFFF.
//  6 Fill 3 entries, assert reset 1 cycle with push=1 -> count=0, pndng_i_in=0, drop_cnt=0.
//    Queue empty after reset.

Source files
------------

// File: rtl/mesh_term_inject_pkg.sv
// -----------------------------------------------------------------------------
// mesh_term_inject_pkg
// Shared definitions for the terminal-side injection buffer.
//   - Packet field offsets. Offsets are counted down from the packet MSB, so a
//     field bit index is (pckg_sz - OFFSET). The same offsets then work for any
//     packet width.
//   - dest_legal(): destination screen. The monitor/checker calls it as well.
// -----------------------------------------------------------------------------
package mesh_term_inject_pkg;

    // Field offsets from the MSB: bit index = pckg_sz - offset
    localparam int NXTJP_MSB = 1;
    localparam int NXTJP_LSB = 8;
    localparam int ROW_MSB   = 9;
    localparam int ROW_LSB   = 12;
    localparam int COL_MSB   = 13;
    localparam int COL_LSB   = 16;
    localparam int MODE_BIT  = 17;

    localparam int NXTJP_W = NXTJP_LSB - NXTJP_MSB + 1;
    localparam int ROW_W   = ROW_LSB - ROW_MSB + 1;
    localparam int COL_W   = COL_LSB - COL_MSB + 1;

    localparam int DROP_CNT_W = 16;

    // A destination is a terminal on the mesh perimeter (excluding corners),
    // or the broadcast code. The terminal's own address is never legal.
    function automatic logic dest_legal(
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] col,
        input int               rows,
        input int               colums,
        input logic [7:0]       bdcst,
        input int               my_row,
        input int               my_col
    );
        int   r;
        int   c;
        logic on_row_edge;
        logic on_col_edge;
        logic is_bcast;
        logic is_self;
        r           = int'(row);
        c           = int'(col);
        on_row_edge = ((r == 0) || (r == rows + 1)) && (c >= 1) && (c <= colums);
        on_col_edge = ((c == 0) || (c == colums + 1)) && (r >= 1) && (r <= rows);
        is_bcast    = ({row, col} == bdcst);
        is_self     = (r == my_row) && (c == my_col);
        return (is_bcast || (on_row_edge ^ on_col_edge)) && !is_self;
    endfunction

endpackage

// File: rtl/mesh_term_inject_if.sv
// -----------------------------------------------------------------------------
// mesh_term_inject_if
// Bundle between a terminal source, the injection buffer and the router port.
//   push / data_in        : source offers a packet
//   full                  : buffer holds fifo_depth entries
//   popin                 : router takes the head entry
//   pndng_i_in / data_out_i_in : head valid / head packet (show-ahead)
//   drop / drop_cnt       : reject pulse and saturating reject count
//   count                 : occupancy
//
// Handshake: a packet moves from source to buffer on a rising clk edge. This
// happens when push=1, the destination is legal, and (full=0 or popin=1).
// Otherwise the push is dropped. A packet moves from buffer to router on the
// edge where pndng_i_in=1 and popin=1. popin with pndng_i_in=0 has no effect.
// -----------------------------------------------------------------------------
interface mesh_term_inject_if #(
    parameter int PCKG_SZ    = 40,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic               push;
    logic [PCKG_SZ-1:0] data_in;
    logic               full;
    logic               popin;
    logic               pndng_i_in;
    logic [PCKG_SZ-1:0] data_out_i_in;
    logic               drop;
    logic [15:0]        drop_cnt;
    logic [CNT_W-1:0]   count;

    // Source/router side
    modport master (
        output push, data_in, popin,
        input  full, pndng_i_in, data_out_i_in, drop, drop_cnt, count
    );

    // Buffer side
    modport slave (
        input  push, data_in, popin,
        output full, pndng_i_in, data_out_i_in, drop, drop_cnt, count
    );

endinterface

// File: rtl/mesh_term_inject_fifo_core.sv
// -----------------------------------------------------------------------------
// mesh_term_inject_fifo_core
// Generic synchronous show-ahead FIFO. rdata_o always shows the entry at the
// read pointer. A pop on an empty FIFO is ignored. A push into a full FIFO is
// taken only when a pop happens on the same edge.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   push_i, wdata_i    write request / data
//   pop_i              read request
//   rdata_o            head entry
//   full_o, empty_o    occupancy flags
//   count_o            occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module mesh_term_inject_fifo_core #(
    parameter  int WIDTH = 40,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // When full, a write is allowed only if the pop on this edge frees a slot
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of 2, so the pointers wrap naturally
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // Storage is cleared so the head output reads zero after reset
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mesh_term_inject.sv
// -----------------------------------------------------------------------------
// mesh_term_inject
// Terminal-side injection buffer in front of one mesh router terminal port.
// The buffer screens the destination of each pushed packet and clears the
// Nxtjp field. It queues accepted packets for the router. Rejected pushes
// produce a one-cycle drop pulse and increment a saturating counter.
// Ports:
//   clk    clock (all logic on posedge)
//   reset  synchronous, active-high
//   bus    mesh_term_inject_if.slave: push/data_in/full from the source side,
//          popin/pndng_i_in/data_out_i_in to the router side,
//          drop/drop_cnt/count status
// -----------------------------------------------------------------------------
module mesh_term_inject
    import mesh_term_inject_pkg::*;
#(
    parameter int         ROWS       = 4,
    parameter int         COLUMS     = 4,
    parameter int         pckg_sz    = 40,
    parameter int         fifo_depth = 4,
    parameter logic [7:0] bdcst      = 8'hFF,
    parameter int         MY_ROW     = 0,
    parameter int         MY_COLUM   = 1
) (
    input logic               clk,
    input logic               reset,
    mesh_term_inject_if.slave bus
);

    localparam int CW = $clog2(fifo_depth) + 1;

    logic [ROW_W-1:0]      row_w;
    logic [COL_W-1:0]      col_w;
    logic                  legal_w;
    logic                  accept_w;
    logic                  reject_w;
    logic [pckg_sz-1:0]    word_w;
    logic                  fifo_full_w;
    logic                  fifo_empty_w;
    logic [CW-1:0]         fifo_count_w;
    logic                  drop_q, drop_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    assign row_w   = bus.data_in[pckg_sz-ROW_MSB -: ROW_W];
    assign col_w   = bus.data_in[pckg_sz-COL_MSB -: COL_W];
    assign legal_w = dest_legal(row_w, col_w, ROWS, COLUMS, bdcst, MY_ROW, MY_COLUM);

    // A full queue still accepts a push when the router pops on the same edge
    assign accept_w = bus.push && legal_w && (!fifo_full_w || bus.popin);
    assign reject_w = bus.push && !accept_w;

    // Stored word: Nxtjp zeroed; all other fields pass through unchanged
    assign word_w = {{NXTJP_W{1'b0}}, row_w, col_w,
                     bus.data_in[pckg_sz-MODE_BIT],
                     bus.data_in[pckg_sz-MODE_BIT-1:0]};

    mesh_term_inject_fifo_core #(
        .WIDTH (pckg_sz),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (accept_w),
        .wdata_i (word_w),
        .pop_i   (bus.popin),
        .rdata_o (bus.data_out_i_in),
        .full_o  (fifo_full_w),
        .empty_o (fifo_empty_w),
        .count_o (fifo_count_w)
    );

    always_comb begin
        drop_d     = reject_w;
        drop_cnt_d = drop_cnt_q;
        if (reject_w && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.full       = fifo_full_w;
    assign bus.pndng_i_in = !fifo_empty_w;
    assign bus.count      = fifo_count_w;
    assign bus.drop       = drop_q;
    assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_mesh_term_inject.sv
// -----------------------------------------------------------------------------
// tb_mesh_term_inject
// Directed and randomized stimulus for mesh_term_inject. The bench checks each
// result against a queue-based reference model of the buffer.
// -----------------------------------------------------------------------------
module tb_mesh_term_inject;

    localparam int         ROWS     = 4;
    localparam int         COLUMS   = 4;
    localparam int         PW       = 40;
    localparam int         DEPTH    = 4;
    localparam int         MY_ROW   = 0;
    localparam int         MY_COLUM = 1;
    localparam logic [7:0] BDCST    = 8'hFF;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mesh_term_inject_if #(.PCKG_SZ(PW), .FIFO_DEPTH(DEPTH)) bus ();

    mesh_term_inject #(
        .ROWS       (ROWS),
        .COLUMS     (COLUMS),
        .pckg_sz    (PW),
        .fifo_depth (DEPTH),
        .bdcst      (BDCST),
        .MY_ROW     (MY_ROW),
        .MY_COLUM   (MY_COLUM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    logic [PW-1:0] exp_q[$];
    int            exp_drop_cnt;
    bit            exp_drop;
    int            term_r[$];
    int            term_c[$];
    int            n_cmp;
    int            n_err;

    // Legal destinations are the terminals on the mesh perimeter
    // (corners excluded), minus this terminal, plus broadcast.
    task automatic build_terminals();
        for (int c = 1; c <= COLUMS; c++) begin
            term_r.push_back(0);        term_c.push_back(c);
            term_r.push_back(ROWS + 1); term_c.push_back(c);
        end
        for (int r = 1; r <= ROWS; r++) begin
            term_r.push_back(r); term_c.push_back(0);
            term_r.push_back(r); term_c.push_back(COLUMS + 1);
        end
    endtask

    function automatic bit ref_legal(input int r, input int c);
        logic [7:0] rc;
        rc = 8'(r * 16 + c);
        if (rc == BDCST) return 1'b1;
        if (r == MY_ROW && c == MY_COLUM) return 1'b0;
        foreach (term_r[i]) if (term_r[i] == r && term_c[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [PW-1:0] mk_pkt(input logic [7:0] nx, input int r, input int c,
                                              input bit mode, input logic [22:0] pl);
        return {nx, 4'(r), 4'(c), mode, pl};
    endfunction

    function automatic logic [PW-1:0] rand_legal_pkt();
        int idx;
        do idx = $urandom_range(0, term_r.size() - 1);
        while (!ref_legal(term_r[idx], term_c[idx]));
        return mk_pkt(8'($urandom), term_r[idx], term_c[idx], 1'($urandom), 23'($urandom));
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ":count"},    64'(bus.count),      64'(exp_q.size()));
        chk({tag, ":pndng"},    64'(bus.pndng_i_in), 64'(exp_q.size() != 0));
        chk({tag, ":full"},     64'(bus.full),       64'(exp_q.size() == DEPTH));
        chk({tag, ":drop"},     64'(bus.drop),       64'(exp_drop));
        chk({tag, ":drop_cnt"}, 64'(bus.drop_cnt),   64'(exp_drop_cnt));
        if (exp_q.size() != 0) chk({tag, ":head"}, 64'(bus.data_out_i_in), 64'(exp_q[0]));
    endtask

    // ---------------- driver tasks ----------------
    // One clock: drive inputs, advance the model, then sample 1 ns after the edge.
    task automatic step(input bit p, input logic [PW-1:0] d, input bit pop,
                        input bit do_check, input string tag);
        bit acc;
        bus.push    = p;
        bus.data_in = d;
        bus.popin   = pop;
        acc = p && ref_legal(int'(d[PW-9 -: 4]), int'(d[PW-13 -: 4]))
                && (exp_q.size() < DEPTH || pop);
        if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
        if (acc) exp_q.push_back({8'h00, d[PW-9:0]});
        exp_drop = p && !acc;
        if (exp_drop && exp_drop_cnt < 65535) exp_drop_cnt++;
        @(posedge clk);
        #1;
        bus.push  = 1'b0;
        bus.popin = 1'b0;
        if (do_check) check_state(tag);
    endtask

    task automatic do_reset(input bit p, input logic [PW-1:0] d);
        bus.push    = p;
        bus.data_in = d;
        bus.popin   = 1'b0;
        reset       = 1'b1;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.push     = 1'b0;
        exp_q.delete();
        exp_drop     = 1'b0;
        exp_drop_cnt = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [PW-1:0] pkt;
        n_cmp        = 0;
        n_err        = 0;
        exp_drop     = 1'b0;
        exp_drop_cnt = 0;
        bus.push     = 1'b0;
        bus.popin    = 1'b0;
        bus.data_in  = '0;
        build_terminals();

        // 1: reset values, then one push with Nxtjp cleared, then pop
        do_reset(1'b0, '0);
        check_state("t1_reset");
        chk("t1_reset:data_out", 64'(bus.data_out_i_in), 64'd0);
        pkt = mk_pkt(8'h5A, 2, 0, 1'b1, 23'd1);
        step(1'b1, pkt, 1'b0, 1'b1, "t1_push");
        chk("t1_push:nxtjp", 64'(bus.data_out_i_in[PW-1 -: 8]), 64'd0);
        step(1'b0, '0, 1'b1, 1'b1, "t1_pop");

        // 2: five back-to-back pushes into depth 4, then drain in order
        for (int i = 0; i < 5; i++) step(1'b1, rand_legal_pkt(), 1'b0, 1'b1, "t2_fill");
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b1, "t2_drain");

        // 3: full queue, push and pop on the same edge
        for (int i = 0; i < 4; i++) step(1'b1, rand_legal_pkt(), 1'b0, 1'b1, "t3_fill");
        step(1'b1, rand_legal_pkt(), 1'b1, 1'b1, "t3_pushpop");
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b1, "t3_drain");

        // 4: illegal destinations, then broadcast
        do_reset(1'b0, '0);
        step(1'b1, mk_pkt(8'h11, 0, 0, 1'b0, 23'h1), 1'b0, 1'b1, "t4_corner");
        step(1'b1, mk_pkt(8'h22, 5, 5, 1'b0, 23'h2), 1'b0, 1'b1, "t4_far_corner");
        step(1'b1, mk_pkt(8'h33, 2, 2, 1'b0, 23'h3), 1'b0, 1'b1, "t4_interior");
        step(1'b1, mk_pkt(8'h44, MY_ROW, MY_COLUM, 1'b0, 23'h4), 1'b0, 1'b1, "t4_self");
        step(1'b1, mk_pkt(8'h55, 15, 15, 1'b1, 23'h5), 1'b0, 1'b1, "t4_bcast");
        step(1'b0, '0, 1'b1, 1'b1, "t4_pop");

        // 5: pop on empty, then saturate the drop counter
        step(1'b0, '0, 1'b1, 1'b1, "t5_pop_empty");
        for (int i = 0; i < 70000; i++) step(1'b1, mk_pkt(8'h00, 0, 0, 1'b0, 23'h0), 1'b0, 1'b0, "t5_sat");
        check_state("t5_saturated");
        step(1'b1, mk_pkt(8'h00, 3, 3, 1'b0, 23'h0), 1'b0, 1'b1, "t5_sat_hold");

        // 6: reset mid-operation with a coincident push
        for (int i = 0; i < 3; i++) step(1'b1, rand_legal_pkt(), 1'b0, 1'b1, "t6_fill");
        do_reset(1'b1, rand_legal_pkt());
        check_state("t6_reset");
        chk("t6_reset:data_out", 64'(bus.data_out_i_in), 64'd0);
        step(1'b0, '0, 1'b0, 1'b1, "t6_idle");

        // 7: randomized traffic, with alternating push-heavy and pop-heavy phases
        for (int i = 0; i < 400; i++) begin
            bit p;
            bit pop;
            p   = ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            pop = ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) pkt = rand_legal_pkt();
            else pkt = mk_pkt(8'($urandom), $urandom_range(0, 15), $urandom_range(0, 15),
                              1'($urandom), 23'($urandom));
            step(p, pkt, pop, 1'b1, "t7_random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
